// File: rtl/spi_master_seq_pkg.sv
// spi_master_seq_pkg
//   Shared types and constants for the SPI master sequencer.
//   op_e    : command opcode carried in the top two frame bits.
//   state_e : sequencer FSM state, also exported on the debug port.
package spi_master_seq_pkg;

  localparam int FRAME_BITS = 10;  // {op[1:0], data[7:0]}
  localparam int RX_BITS    = 8;   // MISO reply width

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SEL   = 3'd2,
    SHIFT = 3'd3,
    END   = 3'd4,
    WAIT  = 3'd5,
    RECV  = 3'd6,
    GAP   = 3'd7
  } state_e;

endpackage

// File: rtl/spi_shreg.sv
// spi_shreg
//   Datapath for the SPI master: a parallel-load, MSB-first transmit shift
//   register and an MSB-first receive shift register.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     load        : load load_frame into the transmit register
//     load_frame  : {op, data} frame to serialise
//     tx_shift    : shift transmit register left by one
//     tx_msb      : current transmit MSB (next bit to drive on MOSI)
//     rx_shift    : shift miso into the receive register
//     miso        : serial input
//     rx_next     : receive register value including the current miso bit,
//                   so the controller can capture a full byte on the last edge
module spi_shreg
  import spi_master_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_frame,
  input  logic                  tx_shift,
  output logic                  tx_msb,
  input  logic                  rx_shift,
  input  logic                  miso,
  output logic [RX_BITS-1:0]    rx_next
);

  logic [FRAME_BITS-1:0] tx_sr;
  logic [RX_BITS-1:0]    rx_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr <= '0;
      rx_sr <= '0;
    end else begin
      if (load) begin
        tx_sr <= load_frame;
      end else if (tx_shift) begin
        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
      end
      if (load) begin
        rx_sr <= '0;
      end else if (rx_shift) begin
        rx_sr <= rx_next;
      end
    end
  end

  assign tx_msb  = tx_sr[FRAME_BITS-1];
  assign rx_next = {rx_sr[RX_BITS-2:0], miso};

endmodule

// File: rtl/spi_master_seq.sv
// spi_master_seq
//   Host-side SPI master sequencer. Takes one command at a time and turns it
//   into a full SPI frame on ss_n/MOSI; RD_DATA frames also collect an 8-bit
//   MISO reply and report it with a one-cycle rsp_valid pulse.
//
//   Handshake: a command transfers on the rising edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is high only in IDLE; a requester that
//   sees cmd_ready low must hold cmd_valid and its payload until it transfers.
//
//   Frame timing (cycle 1 = first cycle after the accept edge):
//     START 1 | SEL 1 | SHIFT 10 | END 1            -> GAP
//     START 1 | SEL 1 | SHIFT 10 | WAIT n | RECV 8  -> GAP (RD_DATA only)
//
//   Parameters: MISO_LAT (>=0) cycles between last MOSI bit and first MISO
//   sample; GAP_CYCLES (>=1) cycles ss_n is held high after each frame.
//   Optional macro SPI_MASTER_SEQ_AUTO_READ_EN adds cmd_auto: an RD_ADDR
//   accepted with cmd_auto=1 is followed automatically by an RD_DATA frame.
//
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     cmd_valid/cmd_ready  : command handshake
//     cmd_op, cmd_data     : opcode and byte
//     cmd_auto             : (macro only) chain an RD_DATA after RD_ADDR
//     rsp_valid, rsp_data  : read reply pulse and held byte
//     busy                 : state != IDLE
//     ss_n, MOSI, MISO     : SPI pins
//     dbg_state            : current FSM state
module spi_master_seq
  import spi_master_seq_pkg::*;
#(
  parameter int MISO_LAT   = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [7:0]   cmd_data,
`ifdef SPI_MASTER_SEQ_AUTO_READ_EN
  input  logic         cmd_auto,
`endif
  output logic         rsp_valid,
  output logic [7:0]   rsp_data,
  output logic         busy,
  output logic         ss_n,
  output logic         MOSI,
  input  logic         MISO,
  output state_e       dbg_state
);

  localparam logic [3:0] SHIFT_INIT = 4'(FRAME_BITS - 1);
  localparam logic [3:0] RECV_INIT  = 4'(RX_BITS - 1);
  localparam logic [7:0] WAIT_INIT  = (MISO_LAT > 0) ? 8'(MISO_LAT - 1) : 8'd0;
  localparam logic [7:0] GAP_INIT   = 8'(GAP_CYCLES - 1);

  state_e          state;
  op_e             cmd_op_e;
  logic [3:0]      bit_cnt;     // SHIFT 9..0, RECV 7..0
  logic [7:0]      dly_cnt;     // WAIT and GAP length
  logic            is_rd_data;  // current frame expects a MISO reply
  logic            accept;
  logic            restart;     // chained RD_DATA starts at end of GAP
  logic            load;
  logic [FRAME_BITS-1:0] load_frame;
  logic            tx_shift;
  logic            tx_msb;
  logic            rx_shift;
  logic [RX_BITS-1:0] rx_next;

  assign cmd_op_e = op_e'(cmd_op);
  assign accept   = (state == IDLE) && cmd_ready && cmd_valid;

`ifdef SPI_MASTER_SEQ_AUTO_READ_EN
  logic auto_pend;
  assign restart = (state == GAP) && (dly_cnt == 8'd0) && auto_pend;
`else
  assign restart = 1'b0;
`endif

  assign load       = accept || restart;
  assign load_frame = restart ? {RD_DATA, 8'h00} : {cmd_op, cmd_data};
  // The transmit register is consumed one bit per edge from SEL until the
  // last SHIFT cycle; MOSI registers tx_msb on the same edges.
  assign tx_shift   = (state == SEL) || ((state == SHIFT) && (bit_cnt != 4'd0));
  assign rx_shift   = (state == RECV);

  spi_shreg u_shreg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_frame (load_frame),
    .tx_shift   (tx_shift),
    .tx_msb     (tx_msb),
    .rx_shift   (rx_shift),
    .miso       (MISO),
    .rx_next    (rx_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      ss_n       <= 1'b1;
      MOSI       <= 1'b0;
      bit_cnt    <= 4'd0;
      dly_cnt    <= 8'd0;
      is_rd_data <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            cmd_ready  <= 1'b0;
            ss_n       <= 1'b0;
            MOSI       <= 1'b0;
            is_rd_data <= (cmd_op_e == RD_DATA);
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        START: begin
          // Frame MSB is op[1], which doubles as the slave's read/write select.
          state <= SEL;
          MOSI  <= tx_msb;
        end
        SEL: begin
          state   <= SHIFT;
          MOSI    <= tx_msb;
          bit_cnt <= SHIFT_INIT;
        end
        SHIFT: begin
          if (bit_cnt == 4'd0) begin
            MOSI <= 1'b0;
            if (!is_rd_data) begin
              state <= END;
            end else if (MISO_LAT == 0) begin
              state   <= RECV;
              bit_cnt <= RECV_INIT;
            end else begin
              state   <= WAIT;
              dly_cnt <= WAIT_INIT;
            end
          end else begin
            MOSI    <= tx_msb;
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        END: begin
          state   <= GAP;
          ss_n    <= 1'b1;
          dly_cnt <= GAP_INIT;
        end
        WAIT: begin
          if (dly_cnt == 8'd0) begin
            state   <= RECV;
            bit_cnt <= RECV_INIT;
          end else begin
            dly_cnt <= dly_cnt - 8'd1;
          end
        end
        RECV: begin
          if (bit_cnt == 4'd0) begin
            state     <= GAP;
            ss_n      <= 1'b1;
            dly_cnt   <= GAP_INIT;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_next;
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        GAP: begin
          if (dly_cnt == 8'd0) begin
            if (restart) begin
              state      <= START;
              ss_n       <= 1'b0;
              is_rd_data <= 1'b1;
            end else begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
          end else begin
            dly_cnt <= dly_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          ss_n  <= 1'b1;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_SEQ_AUTO_READ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_pend <= 1'b0;
    end else if (accept) begin
      auto_pend <= cmd_auto && (cmd_op_e == RD_ADDR);
    end else if (restart) begin
      auto_pend <= 1'b0;
    end
  end
`endif

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq
//   Directed bench for spi_master_seq: reset values, single frames of every
//   opcode with hand-derived MOSI sequences, read replies through an expected
//   queue, reset in mid-frame, back-to-back commands and (with
//   SPI_MASTER_SEQ_AUTO_READ_EN) the chained read.
module tb_spi_master_seq;
  import spi_master_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
`ifdef SPI_MASTER_SEQ_AUTO_READ_EN
  logic       cmd_auto;
`endif
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ss_n;
  logic       MOSI;
  logic       MISO;
  state_e     dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  logic       ss_log  [0:63];
  logic       mosi_log[0:63];
  logic       rv_log  [0:63];
  logic       rdy_log [0:63];
  logic       busy_log[0:63];
  logic [7:0] rd_log  [0:63];

  spi_master_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
`ifdef SPI_MASTER_SEQ_AUTO_READ_EN
    .cmd_auto  (cmd_auto),
`endif
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .ss_n      (ss_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every rsp_valid pulse must match the oldest expected byte
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else chk("rsp_data_sb", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // driver: present a command at a negedge where cmd_ready is high
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    int t;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
  endtask

  // log ncyc cycles after the accept; drive miso_byte MSB-first from cycle rs
  task automatic observe(input int ncyc, input logic [7:0] miso_byte, input int rs);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      ss_log[k]   = ss_n;
      mosi_log[k] = MOSI;
      rv_log[k]   = rsp_valid;
      rdy_log[k]  = cmd_ready;
      busy_log[k] = busy;
      rd_log[k]   = rsp_data;
      if (k >= rs && k < rs + 8) MISO = miso_byte[7-(k-rs)];
      else MISO = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int exp_low, input logic [12:0] exp_mosi,
                             input logic exp_rsp, input logic [7:0] rsp_byte);
    int low, gap_hi, rdy_busy, rv_cnt;
    logic [12:0] mosi_v;
    low = 0;
    while (low < exp_low + 3 && ss_log[low+1] == 1'b0) low++;
    chk({tag, "_low"}, low, exp_low);
    for (int k = 1; k <= 13; k++) mosi_v[13-k] = mosi_log[k];
    chk({tag, "_mosi"}, {19'd0, mosi_v}, {19'd0, exp_mosi});
    gap_hi = 0;
    for (int k = exp_low + 1; k <= exp_low + 3; k++)
      if (ss_log[k] && busy_log[k] && !mosi_log[k]) gap_hi++;
    chk({tag, "_gap"}, gap_hi, 3);
    rdy_busy = 0;
    rv_cnt = 0;
    for (int k = 1; k <= exp_low + 4; k++) begin
      if (k <= exp_low + 3 && rdy_log[k]) rdy_busy++;
      if (rv_log[k]) rv_cnt++;
    end
    chk({tag, "_rdy_low"}, rdy_busy, 0);
    chk({tag, "_rdy_after"}, {31'd0, rdy_log[exp_low+4]}, 32'd1);
    chk({tag, "_rv_cnt"}, rv_cnt, {31'd0, exp_rsp});
    if (exp_rsp) begin
      chk({tag, "_rv_pos"}, {31'd0, rv_log[exp_low+1]}, 32'd1);
      chk({tag, "_rd"}, {24'd0, rd_log[exp_low+1]}, {24'd0, rsp_byte});
      chk({tag, "_rd_hold"}, {24'd0, rd_log[exp_low+4]}, {24'd0, rsp_byte});
    end
  endtask

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } cmd_t;

  initial begin
    cmd_t cmds[4];
    int   acc_cyc[4];
    int   idx, cyc, gap_cnt, rdy_busy;
    logic prev_rdy;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 8'h00;
    MISO = 1'b0;
`ifdef SPI_MASTER_SEQ_AUTO_READ_EN
    cmd_auto = 1'b0;
`endif

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ss_n", {31'd0, ss_n}, 32'd1);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rd", {24'd0, rsp_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", {31'd0, cmd_ready}, 32'd1);

    // WR_ADDR 0x5A
    issue(2'b00, 8'h5A);
    observe(17, 8'h00, 99);
    check_frame("wr_addr", 13, 13'b0000010110100, 1'b0, 8'h00);

    // RD_ADDR 0xC3
    issue(2'b10, 8'hC3);
    observe(17, 8'h00, 99);
    check_frame("rd_addr", 13, 13'b0110110000110, 1'b0, 8'h00);

    // RD_DATA, slave replies 0xA5 from cycle 15
    exp_q.push_back(8'hA5);
    issue(2'b11, 8'h00);
    observe(26, 8'hA5, 15);
    check_frame("rd_data_a5", 22, 13'b0111000000000, 1'b1, 8'hA5);

    // WR_DATA 0x81
    issue(2'b01, 8'h81);
    observe(17, 8'h00, 99);
    check_frame("wr_data", 13, 13'b0001100000010, 1'b0, 8'h00);

    // RD_DATA with dummy 0xFF, slave replies 0x5C
    exp_q.push_back(8'h5C);
    issue(2'b11, 8'hFF);
    observe(26, 8'h5C, 15);
    check_frame("rd_data_5c", 22, 13'b0111111111110, 1'b1, 8'h5C);

    // reset in the middle of SHIFT of a WR_DATA
    issue(2'b01, 8'h3E);
    observe(6, 8'h00, 99);
    chk("mid_ss_low", {31'd0, ss_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ss_n", {31'd0, ss_n}, 32'd1);
    chk("mid_rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rv", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rd", {24'd0, rsp_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("mid_rst_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_state", {29'd0, dbg_state}, {29'd0, IDLE});

    // back-to-back: cmd_valid held high across four commands
    cmds[0] = '{op: 2'b00, data: 8'h11};
    cmds[1] = '{op: 2'b01, data: 8'h22};
    cmds[2] = '{op: 2'b10, data: 8'h33};
    cmds[3] = '{op: 2'b01, data: 8'h44};
    issue(cmds[0].op, cmds[0].data);
    idx = 0;
    cyc = 0;
    gap_cnt = 0;
    rdy_busy = 0;
    prev_rdy = cmd_ready;
    while (idx < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (prev_rdy && cmd_valid) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) begin
          cmd_op = cmds[idx].op;
          cmd_data = cmds[idx].data;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (cmd_ready && busy) rdy_busy++;
      if (ss_n && busy) gap_cnt++;
      prev_rdy = cmd_ready;
    end
    chk("b2b_accepts", idx, 4);
    repeat (20) begin
      @(negedge clk);
      if (cmd_ready && busy) rdy_busy++;
      if (ss_n && busy) gap_cnt++;
    end
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 17);
    chk("b2b_gap_cycles", gap_cnt, 12);
    chk("b2b_ready_busy", rdy_busy, 0);

`ifdef SPI_MASTER_SEQ_AUTO_READ_EN
    // RD_ADDR 0x10 with auto read, slave replies 0x3C in the second frame
    begin
      int low1, hi1, low2, rv_cnt, rdy_cnt;
      logic [12:0] mosi_v;
      exp_q.push_back(8'h3C);
      cmd_auto = 1'b1;
      issue(2'b10, 8'h10);
      observe(42, 8'h3C, 31);
      cmd_auto = 1'b0;
      low1 = 0; hi1 = 0; low2 = 0; rv_cnt = 0; rdy_cnt = 0;
      for (int k = 1; k <= 13; k++) if (!ss_log[k]) low1++;
      for (int k = 14; k <= 16; k++) if (ss_log[k]) hi1++;
      for (int k = 17; k <= 38; k++) if (!ss_log[k]) low2++;
      for (int k = 1; k <= 42; k++) begin
        if (rv_log[k]) rv_cnt++;
        if (k <= 41 && rdy_log[k]) rdy_cnt++;
      end
      for (int k = 1; k <= 13; k++) mosi_v[13-k] = mosi_log[k+16];
      chk("auto_low1", low1, 13);
      chk("auto_gap", hi1, 3);
      chk("auto_low2", low2, 22);
      chk("auto_ss_after", {31'd0, ss_log[39]}, 32'd1);
      chk("auto_mosi2", {19'd0, mosi_v}, {19'd0, 13'b0111000000000});
      chk("auto_rv_cnt", rv_cnt, 1);
      chk("auto_rv_pos", {31'd0, rv_log[39]}, 32'd1);
      chk("auto_rd", {24'd0, rd_log[42]}, {24'd0, 8'h3C});
      chk("auto_rdy_low", rdy_cnt, 0);
      chk("auto_rdy_after", {31'd0, rdy_log[42]}, 32'd1);
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- Host-side SPI master sequencer for the SPI-with-RAM slave wrapper.
- Accepts one command at a time on a valid/ready interface: write-address, write-data, read-address or read-data.
- Serialises each command into a complete SPI frame on ss_n/MOSI and, for read-data, deserialises the 8-bit MISO reply into a response pulse.
- Sits between a CPU/test-bus requester and the SPI wrapper.

Parameters:
- MISO_LAT, 2, cycles after the last MOSI bit before the first MISO bit is sampled (covers the slave's tx_valid turnaround).
- GAP_CYCLES, 3, minimum cycles ss_n is held high between frames.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- cmd_data  in  8  address or data byte; dummy for RD_DATA.
- rsp_valid  out  1  one-cycle pulse when read data is available.
- rsp_data  out  8  captured MISO byte; held until the next capture.
- busy  out  1  high whenever state != IDLE.
- ss_n  out  1  SPI slave select, active low.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - ss_n=1, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=0x00, busy=0, state=IDLE.
  - cmd_ready goes high the cycle after rst deasserts.
- Reset mid-frame: at the next edge ss_n=1, MOSI=0, the command is dropped, no rsp_valid is issued, and the state is IDLE with no GAP.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on the edge where cmd_valid&&cmd_ready; {cmd_op, cmd_data} is latched into a 10-bit frame register.
  - cmd_valid with cmd_ready=0 is ignored and must be held by the requester.
- FSM: IDLE -> START -> SEL -> SHIFT -> (END | WAIT -> RECV) -> GAP -> IDLE. All outputs are registered. Counting from the first cycle after the accept edge:
  - START, 1 cycle: ss_n=0, MOSI=0 (slave moves IDLE->CHK_CMD).
  - SEL, 1 cycle: MOSI=op[1] (slave write/read select).
  - SHIFT, 10 cycles: MOSI = frame[9] down to frame[0], MSB first; a 4-bit counter runs 9..0.
  - END, 1 cycle, non-RD_DATA ops only: ss_n=0, MOSI=0. Total ss_n low = 13 cycles.
  - WAIT, MISO_LAT cycles, RD_DATA only: ss_n=0, MOSI=0.
  - RECV, 8 cycles, RD_DATA only: MISO is shifted into rsp_data MSB first, sampled at the end of each cycle. Total ss_n low = 12+MISO_LAT+8 (22 by default).
  - After RECV: rsp_valid=1 for exactly one cycle, coincident with the first GAP cycle, and rsp_data is updated.
  - GAP, GAP_CYCLES cycles: ss_n=1, MOSI=0. Then IDLE with cmd_ready=1.
- Sequencing: the block does not enforce RD_ADDR-before-RD_DATA ordering; the slave defines that.

Optional Feature:
- Macro: SPI_MASTER_SEQ_AUTO_READ_EN.
- With the macro defined:
  - Adds input cmd_auto (1 bit), sampled at accept.
  - An RD_ADDR accepted with cmd_auto=1 automatically issues a second frame after GAP, with op=RD_DATA and data=0x00, without re-asserting cmd_ready.
  - rsp_valid pulses once, at the end of the second frame.
  - cmd_auto is ignored for all other ops.
- Without the macro: the port is absent; every frame is single-shot.

Decomposition:
- Package spi_master_seq_pkg contains:
  - op_e enum: WR_ADDR, WR_DATA, RD_ADDR, RD_DATA.
  - state_e enum: IDLE, START, SEL, SHIFT, END, WAIT, RECV, GAP.
  - Constants FRAME_BITS=10 and RX_BITS=8.
- Sub-module spi_shreg is natural: a parallel-load MSB-first serialiser plus 8-bit deserialiser with load/shift/capture enables. The FSM and counters stay in spi_master_seq.

Test Plan:
- Reset check: assert rst for 2 cycles mid-SHIFT of a WR_DATA -> next edge ss_n=1, MOSI=0, busy=0, no rsp_valid; cmd_ready=1 the cycle after rst falls.
- WR_ADDR with 0x5A -> ss_n low for 13 cycles; MOSI sequence 0,0,0,0,0,1,0,1,1,0,1,0,0; then ss_n high for 3 cycles; then cmd_ready=1.
- RD_ADDR with 0xC3 -> MOSI 0,1,1,0,1,1,0,0,0,0,1,1,0, with ss_n low for 13 cycles; no rsp_valid.
- RD_DATA with a slave model driving 0xA5 on MISO from cycle 15 (MISO_LAT=2) -> ss_n low for 22 cycles; rsp_valid is a single pulse with rsp_data=0xA5, held after the pulse.
- Back-to-back: cmd_valid held high with 4 commands queued -> each accept is separated by exactly 3 cycles of ss_n=1; cmd_ready is never high while busy=1.
- With SPI_MASTER_SEQ_AUTO_READ_EN: RD_ADDR 0x10 with cmd_auto=1, slave returning 0x3C -> two frames with a 3-cycle gap; a single rsp_valid with rsp_data=0x3C; cmd_ready low throughout.
